// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 16;

  // Internal width used for PC arithmetic; callers truncate to their own
  // address width, which keeps the result modulo 2**ADDR_W.
  localparam int PC_CALC_W = 16;

  // Next sequential or PC-relative target. Halt is resolved by the FSM.
  function automatic logic [PC_CALC_W-1:0] next_pc(
    input logic        [PC_CALC_W-1:0] pc,
    input logic signed [7:0]           offset,
    input logic                        jump,
    input logic                        equality
  );
    logic [PC_CALC_W-1:0] off_ext;
    off_ext = {{(PC_CALC_W-8){offset[7]}}, offset};
    if (jump || equality) begin
      return pc + off_ext;
    end
    return pc + {{(PC_CALC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_unit.sv
// Combinational next-PC selection: sign-extend offset, add, wrap to ADDR_W.
module pc_next_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        [ADDR_W-1:0] pc,
  input  logic signed [7:0]        offset,
  input  logic                     jump,
  input  logic                     equality,
  output logic        [ADDR_W-1:0] pc_next
);

  logic [PC_CALC_W-1:0] pc_ext;
  logic [PC_CALC_W-1:0] sum_full;
  logic                 unused_sum_hi;

  assign pc_ext        = {{(PC_CALC_W-ADDR_W){1'b0}}, pc};
  assign sum_full      = next_pc(pc_ext, offset, jump, equality);
  // Dropping the upper bits is what makes the PC wrap modulo 2**ADDR_W.
  assign pc_next       = sum_full[ADDR_W-1:0];
  assign unused_sum_hi = ^sum_full[PC_CALC_W-1:ADDR_W];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: loader/fetch arbitration of the instruction memory,
// IDLE/RUN/HALT PC sequencing and issued-instruction counting.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  input  logic               jump,
  input  logic               equality,
  input  logic signed [7:0]  offset,
  input  logic               halt,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0]  imem_raddr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   issue_cnt
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_target;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  pc_next_unit #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc       (pc_q),
    .offset   (offset),
    .jump     (jump),
    .equality (equality),
    .pc_next  (pc_target)
  );

  // State, PC and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake/issue decode; rst > abort > start > state action.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    ld_ready    = 1'b0;
    instr_valid = 1'b0;
    // A reset cycle suppresses any write or issue already in flight.
    if (!rst) begin
      if (abort) begin
        state_d = IDLE;
      end else if (start) begin
        state_d = RUN;
        pc_d    = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          RUN: begin
            if (!stall) begin
              instr_valid = 1'b1;
              cnt_d       = sat_inc(cnt_q);
              if (halt) begin
                state_d = HALT;
              end else begin
                pc_d = pc_target;
              end
            end
          end
          HALT: begin
            state_d = HALT;
          end
          // IDLE and the unused code 3 both behave as IDLE.
          default: begin
            state_d  = IDLE;
            ld_ready = 1'b1;
          end
        endcase
      end
    end
  end

  assign imem_we    = ld_valid && ld_ready;
  assign imem_waddr = ld_addr;
  assign imem_wdata = ld_data;
  assign imem_raddr = pc_q;
  assign instr      = imem_rdata;
  assign pc         = pc_q;
  assign state      = state_q;
  assign issue_cnt  = cnt_q;

endmodule
